// File: rtl/instruction_fetch_queue_pkg.sv
// Shared fetch-stage types and constants for the instruction fetch queue and
// the surrounding pipeline.
package instruction_fetch_queue_pkg;

  localparam int FETCH_ADDR_WIDTH  = 32;
  localparam int FETCH_INSTR_WIDTH = 32;
  localparam int PC_STEP_DEFAULT   = 4;

  // Reset vector shared with the rest of the pipeline.
  localparam logic [FETCH_ADDR_WIDTH-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0]  pc;
    logic [FETCH_INSTR_WIDTH-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// Synchronous FIFO with flush; a full FIFO that is popped can accept a push in
// the same cycle.
module instruction_fetch_queue_fetch_fifo
  import instruction_fetch_queue_pkg::*;
#(
  parameter  int DATA_WIDTH  = FETCH_ADDR_WIDTH + FETCH_INSTR_WIDTH,
  parameter  int DEPTH       = 4,
  localparam int PTR_WIDTH   = $clog2(DEPTH),
  localparam int COUNT_WIDTH = PTR_WIDTH + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_WIDTH-1:0]  push_data,
  output logic [DATA_WIDTH-1:0]  head_data,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   full,
  output logic                   empty
);

  logic [DATA_WIDTH-1:0]  mem_reg [DEPTH];
  logic [PTR_WIDTH-1:0]   head_reg, head_next;
  logic [PTR_WIDTH-1:0]   tail_reg, tail_next;
  logic [COUNT_WIDTH-1:0] count_reg, count_next;
  logic                   pop_fire;
  logic                   push_fire;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == COUNT_WIDTH'(DEPTH));
  assign pop_fire  = pop && !empty;
  assign push_fire = push && !flush && (!full || pop_fire);

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_fire) tail_next = tail_reg + PTR_WIDTH'(1);
      if (pop_fire)  head_next = head_reg + PTR_WIDTH'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_next = count_reg + COUNT_WIDTH'(1);
        2'b01:   count_next = count_reg - COUNT_WIDTH'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push_fire) mem_reg[tail_reg] <= push_data;
  end

  assign head_data = empty ? '0 : mem_reg[head_reg];
  assign count     = count_reg;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the PC, reads a combinational instruction memory and
// buffers {pc, instruction} pairs for decode behind a valid/ready handshake.
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter  int                    ADDR_WIDTH  = FETCH_ADDR_WIDTH,
  parameter  int                    INSTR_WIDTH = FETCH_INSTR_WIDTH,
  parameter  int                    QUEUE_DEPTH = 4,
  parameter  logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter  int                    PC_STEP     = PC_STEP_DEFAULT,
  localparam int                    COUNT_WIDTH = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [COUNT_WIDTH-1:0] occupancy,
  output logic [31:0]            fetch_count
);

  localparam int ENTRY_WIDTH = ADDR_WIDTH + INSTR_WIDTH;

  logic [ADDR_WIDTH-1:0]  fetch_pc_reg, fetch_pc_next;
  logic [31:0]            fetch_count_reg, fetch_count_next;
  logic [ENTRY_WIDTH-1:0] head_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   push;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // Popping a full queue frees the slot this cycle, keeping one fetch per cycle.
  assign push      = !redirect_valid && (!fifo_full || pop);

  instruction_fetch_queue_fetch_fifo #(
    .DATA_WIDTH (ENTRY_WIDTH),
    .DEPTH      (QUEUE_DEPTH)
  ) u_fetch_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data ({fetch_pc_reg, imem_rdata}),
    .head_data (head_data),
    .count     (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    fetch_count_next = fetch_count_reg;
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc;
    end else if (push) begin
      fetch_pc_next    = fetch_pc_reg + ADDR_WIDTH'(PC_STEP);
      fetch_count_next = fetch_count_reg + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      fetch_count_reg <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  assign imem_addr             = fetch_pc_reg;
  assign {out_pc, out_instr}   = head_data;
  assign fetch_count           = fetch_count_reg;

endmodule
